// File: rtl/riscv_pkg.sv
// Shared definitions for the serial link blocks (receiver and transmitter).
//   UART_DATA_BITS            : payload bits per 8N1 frame
//   UART_DEFAULT_CLKS_PER_BIT : 100 MHz system clock / 115200 baud
//   uart_tx_state_e           : transmitter frame-sequencer states
package riscv_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous FIFO with fall-through head (rdata is valid whenever !empty).
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset (pointers only)
//   push, wdata      : write request; ignored while full
//   pop              : read request; ignored while empty
//   rdata            : current head entry
//   full, empty      : derived from registered pointers only
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: contents are only read between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter, LSB first, idle-high line.
// Ports:
//   clk            : system clock, rising edge
//   rst            : asynchronous, active-low reset; abandons frame and queue
//   io_data_valid  : producer presents io_data_packet
//   io_data_packet : byte to send
//   io_ready       : queue not full
//   io_tx          : registered serial output
//   io_busy        : frame in progress or bytes queued
// Handshake: a byte is transferred on a rising edge where io_data_valid and
// io_ready are both high; io_ready never depends on io_data_valid, and a
// byte offered while io_ready is low is silently dropped.
module uart_tx
  import riscv_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      io_data_valid,
  input  logic [UART_DATA_BITS-1:0] io_data_packet,
  output logic                      io_ready,
  output logic                      io_tx,
  output logic                      io_busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = {{(BAUD_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);

  uart_tx_state_e            state_q, state_d;
  logic [BAUD_W-1:0]         baud_q, baud_d;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                      tx_q, tx_d;

  logic                      fifo_pop;
  logic [UART_DATA_BITS-1:0] fifo_rdata;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      baud_end;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (io_data_valid),
    .wdata (io_data_packet),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign baud_end = (baud_q == BAUD_LAST);
  assign io_ready = !fifo_full;
  assign io_busy  = (state_q != IDLE) || !fifo_empty;
  assign io_tx    = tx_q;

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    fifo_pop = 1'b0;
    baud_d   = baud_end ? '0 : baud_q + BAUD_ONE;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_rdata;
          bit_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        if (baud_end) state_d = DATA;
      end
      DATA: begin
        if (baud_end) begin
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            shreg_d = shreg_q >> 1;
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        // Chain straight into the next start bit when more data is queued.
        if (baud_end) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_rdata;
            bit_d    = '0;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) baud_d = '0;

    // The line value is registered from the next state so io_tx changes on
    // the same edge the sequencer does.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: fast instance (4 clocks/bit, 4-deep queue) under a
// frame-sampling scoreboard, plus a default-baud instance timed directly.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
  localparam int SLOW  = 868;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUTs ----------------
  logic       valid = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       ready, tx, busy;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .io_data_valid(valid), .io_data_packet(data),
    .io_ready(ready), .io_tx(tx), .io_busy(busy)
  );

  logic       s_valid = 1'b0;
  logic [7:0] s_data  = 8'h00;
  logic       s_ready, s_tx, s_busy;

  uart_tx #(.CLKS_PER_BIT(SLOW), .FIFO_DEPTH(4)) dut_slow (
    .clk(clk), .rst(rst), .io_data_valid(s_valid), .io_data_packet(s_data),
    .io_ready(s_ready), .io_tx(s_tx), .io_busy(s_busy)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  int start_times[$];

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Monitor: treats the line as a receiver would, capturing every cycle of
  // a frame from its first low sample and comparing against the ideal
  // 8N1 waveform of the next expected byte.
  logic              mon_active = 1'b0;
  int                mon_n = 0;
  logic [FRAME-1:0]  mon_frame;

  always @(negedge clk) begin
    if (!rst) begin
      mon_active = 1'b0;
      mon_n      = 0;
    end else if (!mon_active) begin
      if (tx == 1'b0) begin
        mon_active   = 1'b1;
        mon_frame[0] = 1'b0;
        mon_n        = 1;
        start_times.push_back(cyc);
      end
    end else begin
      mon_frame[mon_n] = tx;
      mon_n++;
      if (mon_n == FRAME) begin
        logic [FRAME-1:0] ev;
        logic [7:0] e;
        mon_active = 1'b0;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL frame: got unexpected frame %b, expected none", mon_frame);
        end else begin
          e = exp_q.pop_front();
          for (int i = 0; i < FRAME; i++) begin
            int b;
            b = i / CPB;
            if (b == 0)      ev[i] = 1'b0;
            else if (b == 9) ev[i] = 1'b1;
            else             ev[i] = e[b-1];
          end
          if (mon_frame != ev) begin
            fails++;
            $display("FAIL frame: got %b expected %b (byte %02h)", mon_frame, ev, e);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_byte(input logic [7:0] d, output logic acc);
    @(negedge clk);
    data  = d;
    valid = 1'b1;
    acc   = ready;
    if (acc) exp_q.push_back(d);
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_active || busy) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain_timeout"}, (n < 6000) ? 1 : 0, 1);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic acc;
    int   base;
    logic exp_rdy [6];

    // Reset state
    #12;
    check("reset_tx", tx, 1);
    check("reset_ready", ready, 1);
    check("reset_busy", busy, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("idle_tx", tx, 1);

    // Single byte: latency and frame length
    push_byte(8'hA3, acc);
    @(negedge clk);
    check("latency_before_start", tx, 1);
    @(negedge clk);
    check("latency_start_bit", tx, 0);
    repeat (39) @(negedge clk);
    check("busy_last_stop", busy, 1);
    @(negedge clk);
    check("busy_after_frame", busy, 0);
    drain("single");

    // Extremes: contiguous frames
    base = start_times.size();
    push_byte(8'h00, acc);
    push_byte(8'hFF, acc);
    drain("extremes");
    check("extremes_frames", start_times.size() - base, 2);
    if (start_times.size() - base == 2)
      check("extremes_gap", start_times[base+1] - start_times[base], FRAME);

    // Overflow: one byte per cycle, four queue behind the active frame
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      push_byte(8'h10 + 8'(i), acc);
      check($sformatf("overflow_ready_%0d", i), acc, exp_rdy[i]);
    end
    drain("overflow");

    // Simultaneous push/pop on the STOP->START pop edge
    base = start_times.size();
    push_byte(8'h61, acc);
    push_byte(8'h62, acc);
    repeat (39) @(posedge clk);
    push_byte(8'h63, acc);
    check("simul_accept", acc, 1);
    drain("simul");
    check("simul_frames", start_times.size() - base, 3);
    if (start_times.size() - base == 3) begin
      check("simul_gap0", start_times[base+1] - start_times[base], FRAME);
      check("simul_gap1", start_times[base+2] - start_times[base+1], FRAME);
    end

    // Reset mid-frame during data bit 3 with two bytes queued
    push_byte(8'h5A, acc);
    push_byte(8'hC1, acc);
    push_byte(8'h3E, acc);
    repeat (16) @(posedge clk);
    #2 rst = 1'b0;
    exp_q.delete();
    #1;
    check("midreset_tx", tx, 1);
    check("midreset_busy", busy, 0);
    check("midreset_ready", ready, 1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    base = start_times.size();
    repeat (100) @(negedge clk);
    check("midreset_no_frame", start_times.size() - base, 0);
    check("midreset_idle_busy", busy, 0);

    // Randomized traffic
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 60)) @(negedge clk);
      push_byte(8'($urandom_range(0, 255)), acc);
    end
    drain("random");

    // Default baud instance: 0x55 alternates every bit
    begin
      int   idx;
      int   cnt;
      logic lvl;
      int   runs[$];
      int   busy_fall;
      @(negedge clk);
      s_data  = 8'h55;
      s_valid = 1'b1;
      @(posedge clk);
      #1 s_valid = 1'b0;
      idx = 0;
      while (s_tx == 1'b1 && idx < 10) begin
        @(negedge clk);
        idx++;
      end
      check("slow_start_seen", (s_tx == 1'b0) ? 1 : 0, 1);
      cnt = 1; lvl = 1'b0; idx = 0; busy_fall = -1;
      while (busy_fall < 0 && idx < 10000) begin
        @(negedge clk);
        idx++;
        if (!s_busy) busy_fall = idx;
        if (runs.size() < 9) begin
          if (s_tx == lvl) cnt++;
          else begin
            runs.push_back(cnt);
            cnt = 1;
            lvl = s_tx;
          end
        end
      end
      check("slow_runs", runs.size(), 9);
      foreach (runs[i]) check($sformatf("slow_bit_len_%0d", i), runs[i], SLOW);
      check("slow_frame_len", busy_fall, 10 * SLOW);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
